// File: rtl/mult_div_sequencer.sv
// Iterative radix-2 multiply/divide engine with its sequencing FSM and the
// architectural HI/LO registers; one operation in flight, restartable and flushable.
module mult_div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             op_mult_i,
    input  logic             op_signed_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               mult_q, mult_d, signed_q, signed_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   md_q, md_d;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   mq_q, mq_d;     // multiplier / quotient shift register
    logic [WIDTH:0]     acc_q, acc_d;   // product upper half / partial remainder
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    // Datapath helpers shared by the PREP, ITER and FIX steps
    always_comb begin
        mag_a     = (signed_q && a_q[WIDTH-1]) ? WIDTH'(-a_q) : a_q;
        mag_b     = (signed_q && b_q[WIDTH-1]) ? WIDTH'(-b_q) : b_q;
        add_sum   = acc_q + (mq_q[0] ? {1'b0, md_q} : (WIDTH+1)'(0));
        div_shift = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, md_q};
        prod      = {acc_q[WIDTH-1:0], mq_q};
        prod_fix  = (signed_q && (sign_a_q ^ sign_b_q)) ? (2*WIDTH)'(-prod) : prod;
        quot_fix  = (signed_q && (sign_a_q ^ sign_b_q)) ? WIDTH'(-mq_q) : mq_q;
        rem_fix   = (signed_q && sign_a_q) ? WIDTH'(-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        mult_d   = mult_q;
        signed_d = signed_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        md_d     = md_q;
        mq_d     = mq_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else if (start_i) begin
            // New start always wins over whatever is in flight
            state_d  = S_PREP;
            a_d      = op_a_i;
            b_d      = op_b_i;
            mult_d   = op_mult_i;
            signed_d = op_signed_i;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_PREP: begin
                    sign_a_d = signed_q & a_q[WIDTH-1];
                    sign_b_d = signed_q & b_q[WIDTH-1];
                    md_d     = mult_q ? mag_a : mag_b;
                    mq_d     = mult_q ? mag_b : mag_a;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_ITER;
                end
                S_ITER: begin
                    if (mult_q) begin
                        acc_d = {1'b0, add_sum[WIDTH:1]};
                        mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
                    end else if (!div_trial[WIDTH]) begin
                        acc_d = div_trial;
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
                end
                S_FIX: begin
                    hi_d    = mult_q ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
                    lo_d    = mult_q ? prod_fix[WIDTH-1:0] : quot_fix;
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_PREP) || (state_d == S_ITER) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
        dz_d   = (state_d == S_DONE) && !mult_q && (b_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mult_q   <= 1'b0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            md_q     <= '0;
            mq_q     <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mult_q   <= mult_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            md_q     <= md_d;
            mq_q     <= mq_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Bench for mult_div_sequencer: arithmetic reference with a completion countdown,
// directed literal vectors plus randomized starts, restarts and flushes.
module tb_mult_div_sequencer;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, flush, op_mult, op_signed;
    logic [W-1:0]  op_a, op_b;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    mult_div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .flush_i    (flush),
        .op_a_i     (op_a),
        .op_b_i     (op_b),
        .op_mult_i  (op_mult),
        .op_signed_i(op_signed),
        .busy_o     (busy),
        .done_o     (done),
        .div_zero_o (div_zero),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic rules
    function automatic void ref_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic m, input logic s,
                                     output logic [W-1:0] h, output logic [W-1:0] l,
                                     output logic dz);
        longint     sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        if (m) begin
            if (s) p = 64'(sa * sb);
            else   p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == '0) begin
            dz = 1'b1;
            h  = a;
            l  = (s && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
        end else if (s) begin
            q = sa / sb;
            r = sa % sb;
            h = 32'(r);
            l = 32'(q);
        end else begin
            h = a % b;
            l = a / b;
        end
    endfunction

    // Model: an op completes LAT edges after its start unless restarted or flushed
    logic         m_active;
    int           m_cnt;
    logic [W-1:0] m_hi, m_lo;
    logic         m_dz;
    logic         e_busy, e_done, e_dz;
    logic [W-1:0] e_hi, e_lo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_hi     = '0;
            m_lo     = '0;
            m_dz     = 1'b0;
            e_busy   = 1'b0;
            e_done   = 1'b0;
            e_dz     = 1'b0;
            e_hi     = '0;
            e_lo     = '0;
        end else begin
            e_done = 1'b0;
            e_dz   = 1'b0;
            if (flush) begin
                m_active = 1'b0;
            end else if (start) begin
                ref_calc(op_a, op_b, op_mult, op_signed, m_hi, m_lo, m_dz);
                m_active = 1'b1;
                m_cnt    = LAT;
            end else if (m_active) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_active = 1'b0;
                    e_hi     = m_hi;
                    e_lo     = m_lo;
                    e_done   = 1'b1;
                    e_dz     = m_dz;
                end
            end
            e_busy = m_active;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("div_zero", 64'(div_zero), 64'(e_dz));
            chk("hi", 64'(hi), 64'(e_hi));
            chk("lo", 64'(lo), 64'(e_lo));
            if (done) n_done++;
        end
    end

    task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic m, input logic s);
        @(negedge clk);
        op_a = a; op_b = b; op_mult = m; op_signed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic m, input logic s,
                            input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        int cyc;
        pulse_start(a, b, m, s);
        wait_done(cyc);
        chk({name, "_latency"}, 64'(cyc), 64'(LAT + 1));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
        chk({name, "_dz"}, 64'(div_zero), 64'(edz));
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int cyc, d0;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0; op_mult = 1'b0; op_signed = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("umul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h1, 1'b0);
        directed("smul_neg", 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        directed("smul_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
        directed("udiv", 32'd100, 32'd7, 1'b0, 1'b0, 32'd2, 32'd14, 1'b0);
        directed("sdiv", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        directed("udiv0", 32'd5, 32'd0, 1'b0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        directed("sdiv0_neg", 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd1, 1'b1);
        directed("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'h8000_0000, 1'b0);

        // Restart mid-op: only the second operation completes
        d0 = n_done;
        pulse_start(32'd2, 32'd3, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        pulse_start(32'd4, 32'd5, 1'b1, 1'b0);
        wait_done(cyc);
        chk("restart_latency", 64'(cyc), 64'(LAT + 1));
        chk("restart_hi", 64'(hi), 64'd0);
        chk("restart_lo", 64'(lo), 64'd20);
        repeat (5) @(negedge clk);
        chk("restart_ndone", 64'(n_done - d0), 64'd1);

        // Flush mid-op: busy drops, no done, HI/LO keep 0/20
        d0 = n_done;
        pulse_start(32'd9, 32'd9, 1'b1, 1'b0);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_ndone", 64'(n_done - d0), 64'd0);
        chk("flush_hi", 64'(hi), 64'd0);
        chk("flush_lo", 64'(lo), 64'd20);

        // Async reset during ITER clears everything at once
        pulse_start(32'd6, 32'd7, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("after_rst", 32'd6, 32'd7, 1'b1, 1'b0, 32'd0, 32'd42, 1'b0);

        // Back-to-back: next start issued during the DONE cycle
        pulse_start(32'd3, 32'd4, 1'b1, 1'b0);
        wait_done(cyc);
        chk("b2b_first_lo", 64'(lo), 64'd12);
        op_a = 32'd50; op_b = 32'd8; op_mult = 1'b0; op_signed = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("b2b_latency", 64'(cyc), 64'(LAT + 1));
        chk("b2b_lo", 64'(lo), 64'd6);
        chk("b2b_hi", 64'(hi), 64'd2);

        // Randomized traffic with occasional double starts and flushes
        repeat (150) begin
            @(negedge clk);
            op_a = pick(); op_b = pick();
            op_mult = 1'($urandom_range(0, 1));
            op_signed = 1'($urandom_range(0, 1));
            start = 1'b1;
            if ($urandom_range(0, 9) == 0) @(negedge clk);
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(1, 45)) begin
                flush = ($urandom_range(0, 99) == 0);
                @(negedge clk);
                flush = 1'b0;
            end
        end
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
